lfsr_prng_arbiter: RTL and testbench

//  Owns one parity-feedback PRNG register (same shift/feedback rule as the LFSR_8BITS/16BITS blocks)
//  and shares it between NUM_REQ requesters. Sequences seed/init load and warm-up, then grants

---
 rtl/lfsr_prng_arbiter.sv | 158 +++++++++++++++
 tb/tb_lfsr_prng_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_arbiter.sv
// Purpose : one parity-feedback PRNG register shared round-robin between NUM_REQ requesters;
//           sequences seed/init load, warm-up, then grants fresh words spaced STRIDE steps apart.
// Latency : grant, rnd_valid and rnd_data are registered one cycle after req is seen in READY.
// Backpr. : requesters hold req until their gnt pulse; at most one grant per STRIDE+1 cycles.
// Optional: `define LFSR_LOCKUP_DETECT_EN enables all-zero lock-up recovery and err_lockup.
// Ports   : clk, rst (sync, active-high); cfg_init/cfg_seed/cfg_load config load;
//           req[NUM_REQ] in; gnt[NUM_REQ], rnd_valid, rnd_data[WIDTH], busy, err_lockup out.
module lfsr_prng_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int WARMUP  = 16,
   parameter int STRIDE  = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   cfg_init,
   input  logic [WIDTH-1:0]   cfg_seed,
   input  logic               cfg_load,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [WIDTH-1:0]   rnd_data,
   output logic               busy,
   output logic               err_lockup
);

   localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX  = (WARMUP > STRIDE) ? WARMUP : STRIDE;
   localparam int CW    = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
   localparam int WU_M1 = (WARMUP > 0) ? WARMUP - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_READY  = 2'd2,
      ST_REFILL = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [WIDTH-1:0]   seed_q, seed_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rnd_valid_q, rnd_valid_d;
   logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
   logic               err_lockup_q, err_lockup_d;

   logic [WIDTH-1:0]   s_step;
   logic               lockup;
   logic               win_found;
   logic [PW-1:0]      win_idx;
   int                 idx;

   // Shift left, feedback = parity of state XOR parity of seed.
   assign s_step = {s_q[WIDTH-2:0], (^s_q) ^ (^seed_q)};

`ifdef LFSR_LOCKUP_DETECT_EN
   // All-zero state with even-parity seed can never leave zero.
   assign lockup = (state_q != ST_IDLE) && (s_q == '0) && !(^seed_q);
`else
   assign lockup = 1'b0;
`endif

   // Round-robin search starting just after the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      seed_d       = seed_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = '0;
      rnd_valid_d  = 1'b0;
      rnd_data_d   = rnd_data_q;
      err_lockup_d = err_lockup_q;

      if (cfg_load) begin
         // Load wins over everything; any grant decision this cycle is dropped.
         s_d          = cfg_init;
         seed_d       = cfg_seed;
         err_lockup_d = 1'b0;
         if (WARMUP > 0) begin
            cnt_d   = CW'(WU_M1);
            state_d = ST_WARMUP;
         end else begin
            state_d = ST_READY;
         end
      end else begin
         if (lockup) begin
            s_d          = WIDTH'(1);
            err_lockup_d = 1'b1;
         end
         case (state_q)
            ST_WARMUP, ST_REFILL: begin
               if (!lockup) s_d = s_step;
               if (cnt_q == '0) state_d = ST_READY;
               else             cnt_d   = cnt_q - 1'b1;
            end
            ST_READY: begin
               // A lock-up fix in this cycle defers the grant by one cycle.
               if (!lockup && win_found) begin
                  gnt_d       = NUM_REQ'(1) << win_idx;
                  rnd_valid_d = 1'b1;
                  rnd_data_d  = s_q;
                  rr_ptr_d    = win_idx;
                  cnt_d       = CW'(STRIDE - 1);
                  state_d     = ST_REFILL;
               end
            end
            default: ; // IDLE: wait for cfg_load
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         s_q          <= '0;
         seed_q       <= '0;
         cnt_q        <= '0;
         rr_ptr_q     <= PW'(NUM_REQ - 1);
         gnt_q        <= '0;
         rnd_valid_q  <= 1'b0;
         rnd_data_q   <= '0;
         err_lockup_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         seed_q       <= seed_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         rnd_valid_q  <= rnd_valid_d;
         rnd_data_q   <= rnd_data_d;
         err_lockup_q <= err_lockup_d;
      end
   end

   assign gnt        = gnt_q;
   assign rnd_valid  = rnd_valid_q;
   assign rnd_data   = rnd_data_q;
   assign busy       = (state_q != ST_READY);
   assign err_lockup = err_lockup_q;

endmodule

// File: tb/tb_lfsr_prng_arbiter.sv
// Bench for lfsr_prng_arbiter: directed phases plus random req/load/reset traffic,
// checked every cycle against a step-count reference model.
module tb_lfsr_prng_arbiter;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int WARMUP  = 16;
   localparam int STRIDE  = WIDTH;
`ifdef LFSR_LOCKUP_DETECT_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [WIDTH-1:0]   cfg_init = '0;
   logic [WIDTH-1:0]   cfg_seed = '0;
   logic               cfg_load = 1'b0;
   logic [NUM_REQ-1:0] req = '0;
   logic [NUM_REQ-1:0] gnt;
   logic               rnd_valid;
   logic [WIDTH-1:0]   rnd_data;
   logic               busy;
   logic               err_lockup;

   int n_cmp = 0;
   int n_err = 0;
   int cycle = 0;

   lfsr_prng_arbiter #(
      .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .WARMUP(WARMUP), .STRIDE(STRIDE)
   ) dut (
      .clk(clk), .rst(rst), .cfg_init(cfg_init), .cfg_seed(cfg_seed),
      .cfg_load(cfg_load), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
      .rnd_data(rnd_data), .busy(busy), .err_lockup(err_lockup)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, obs, exp);
      end
   endtask

   // Reference model: "steps_left" counts PRNG steps still owed before a grant can happen.
   bit                 m_active;
   int                 m_left;
   int                 m_rr;
   logic [WIDTH-1:0]   m_s, m_seed, m_data;
   logic [NUM_REQ-1:0] m_gnt;
   bit                 m_vld, m_err;

   function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] seed);
      int fb;
      fb = ($countones(s) + $countones(seed)) % 2;
      return WIDTH'((int'(s) * 2 + fb) % (1 << WIDTH));
   endfunction

   always @(posedge clk) begin
      m_gnt = '0;
      m_vld = 1'b0;
      if (rst) begin
         m_active = 1'b0; m_left = 0; m_rr = NUM_REQ - 1;
         m_s = '0; m_seed = '0; m_data = '0; m_err = 1'b0;
      end else if (cfg_load) begin
         m_s = cfg_init; m_seed = cfg_seed; m_left = WARMUP;
         m_active = 1'b1; m_err = 1'b0;
      end else if (m_active) begin
         if (LOCK && m_s == 0 && ($countones(m_seed) % 2) == 0) begin
            m_s = 1; m_err = 1'b1;
            if (m_left > 0) m_left--;
         end else if (m_left > 0) begin
            m_s = next_word(m_s, m_seed);
            m_left--;
         end else if (req != 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               int w;
               w = (m_rr + k) % NUM_REQ;
               if (m_gnt == 0 && req[w]) begin
                  m_gnt = 1 << w;
                  m_rr  = w;
               end
            end
            m_vld  = 1'b1;
            m_data = m_s;
            m_left = STRIDE;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      cycle++;
      chk("gnt",        32'(gnt),        32'(m_gnt));
      chk("rnd_valid",  32'(rnd_valid),  32'(m_vld));
      chk("rnd_data",   32'(rnd_data),   32'(m_data));
      chk("busy",       32'(busy),       32'(!(m_active && m_left == 0)));
      chk("err_lockup", 32'(err_lockup), 32'(m_err));
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   task automatic load(input logic [WIDTH-1:0] init, input logic [WIDTH-1:0] seed);
      cfg_init = init; cfg_seed = seed; cfg_load = 1'b1;
      cyc();
      cfg_load = 1'b0;
   endtask

   initial begin
      int last;
      int k;

      // Reset held 2 cycles with req high, then no load: nothing may come out.
      rst = 1'b1; req = 4'hF;
      repeat (2) cyc();
      rst = 1'b0;
      repeat (20) cyc();

      // Known seed, single requester held.
      req = 4'b0001;
      load(8'h01, 8'h00);
      repeat (60) cyc();

      // Fresh reset, all requesters held: rotation and fixed spacing.
      rst = 1'b1; cyc(); rst = 1'b0;
      req = 4'hF;
      load(8'h5A, 8'h3C);
      last = -1; k = 0;
      repeat (WARMUP + 5 * (STRIDE + 1) + 2) begin
         cyc();
         if (gnt != 0) begin
            chk("rr_seq", 32'(gnt), 32'(1 << (k % NUM_REQ)));
            if (last >= 0) chk("gap", 32'(cycle - last), 32'(STRIDE + 1));
            last = cycle;
            k++;
         end
      end
      chk("grant_count", 32'(k >= 5), 32'd1);

      // Reload in the third REFILL cycle after a grant.
      while (gnt == 0 && cycle < 2000) cyc();
      repeat (2) cyc();
      load(8'hC3, 8'h81);
      repeat (WARMUP + 3 * (STRIDE + 1)) cyc();

      // All-zero init with even-parity seed.
      load(8'h00, 8'h03);
      repeat (WARMUP + 4 * (STRIDE + 1)) cyc();

      // rst and cfg_load together while READY, then a normal restart.
      req = '0;
      load(8'h11, 8'h22);
      repeat (WARMUP + 3) cyc();
      rst = 1'b1; cfg_load = 1'b1; cfg_init = 8'h77;
      cyc();
      rst = 1'b0; cfg_load = 1'b0; req = 4'hF;
      repeat (10) cyc();
      load(8'h29, 8'h40);
      repeat (WARMUP + 3 * (STRIDE + 1)) cyc();

      // Random traffic with occasional loads and resets.
      repeat (1500) begin
         req      = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
         cfg_init = WIDTH'($urandom);
         cfg_seed = WIDTH'($urandom);
         if ($urandom_range(0, 7) == 0) cfg_init = '0;
         cfg_load = ($urandom_range(0, 59) == 0);
         rst      = ($urandom_range(0, 399) == 0);
         cyc();
      end
      rst = 1'b0; cfg_load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
